// File: rtl/spi_tx_queue_if.sv
// Connection bundle for spi_tx_queue. It carries the command-handler push side,
// the queue status outputs and the SPI slave write port.
interface spi_tx_queue_if #(
  parameter int AW = 3
);
  logic          push_en;
  logic [23:0]   push_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          spi_wr_buffer_free;
  logic          spi_wr_en;
  logic [23:0]   spi_wr_data;

  modport master (
    output push_en, push_data, flush, spi_wr_buffer_free,
    input  full, empty, level, overflow, spi_wr_en, spi_wr_data
  );

  modport slave (
    input  push_en, push_data, flush, spi_wr_buffer_free,
    output full, empty, level, overflow, spi_wr_en, spi_wr_data
  );
endinterface

// File: rtl/spi_tx_queue.sv
// Reply-word FIFO that sends queued words to the SPI slave one at a time.
// Each word gets one write strobe, and the slave confirms the write through wr_buffer_free.
module spi_tx_queue #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int TAKE_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  spi_tx_queue_if.slave  q
);
  localparam int TW = $clog2(TAKE_TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TAKEN, WAIT_FREE} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic            full_reg, empty_reg, overflow_reg;
  logic [23:0]     wr_data_reg;
  logic [23:0]     mem [DEPTH];
  logic            push_ok, pop;

  // A push in a flush cycle or while full is dropped. A pop in the same cycle does not make room.
  assign push_ok = q.push_en && !q.flush && (count_reg != DEPTH_CNT);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((count_reg != '0) && q.spi_wr_buffer_free && !q.flush) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_TAKEN;
        timer_next = '0;
      end
      WAIT_TAKEN: begin
        if (!q.spi_wr_buffer_free) begin
          state_next = WAIT_FREE;
        end else if (timer_reg == TW'(TAKE_TIMEOUT - 1)) begin
          // The slave took the word without ever showing a busy phase.
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_FREE: begin
        if (q.spi_wr_buffer_free) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (q.flush) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      wr_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      empty_reg <= (count_next == '0);
      if (q.flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (q.push_en && (count_reg == DEPTH_CNT)) overflow_reg <= 1'b1;
      end
      if (pop) wr_data_reg <= mem[rd_ptr_reg];
    end
  end

  // The storage array has no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= q.push_data;
  end

  assign q.full        = full_reg;
  assign q.empty       = empty_reg;
  assign q.level       = count_reg;
  assign q.overflow    = overflow_reg;
  assign q.spi_wr_en   = (state_reg == ISSUE);
  assign q.spi_wr_data = wr_data_reg;
endmodule

// File: tb/tb_spi_tx_queue.sv
// Self-checking bench for spi_tx_queue. The slave model holds wr_buffer_free low for busy_len cycles
// after each strobe, or never drops it when busy_len is 0.
module tb_spi_tx_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_tx_queue_if #(.AW(AW)) bus ();

  spi_tx_queue #(.DEPTH(DEPTH), .AW(AW), .TAKE_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic hold = 1'b1;
  int busy_len = 4;
  int busy_cnt = 0;
  logic [23:0] cap_data[$];
  int cap_cyc[$];

  assign bus.spi_wr_buffer_free = !(hold || (busy_cnt != 0));

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: it records each strobe and then holds free low for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.spi_wr_en === 1'b1) begin
        cap_data.push_back(bus.spi_wr_data);
        cap_cyc.push_back(cyc);
        busy_cnt = busy_len;
        $display("strobe cyc=%0d data=%06h", cyc, bus.spi_wr_data);
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_push(input logic [23:0] d);
    bus.push_en = 1'b1;
    bus.push_data = d;
    @(negedge clk);
    bus.push_en = 1'b0;
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_cyc.delete();
  endtask

  task automatic test_reset();
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.spi_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", bus.spi_wr_en); end
    checks++; if (bus.spi_wr_data !== 24'h0) begin errors++; $display("FAIL reset_wr_data got=%06h exp=000000", bus.spi_wr_data); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int k;
    hold = 1'b0; busy_len = 4; clear_caps();
    k = cyc;
    drive_push(24'hABCDEF);
    checks++; if (bus.level !== 4'd1) begin errors++; $display("FAIL single_level1 got=%0d exp=1", bus.level); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_empty0 got=%b exp=0", bus.empty); end
    idle(20);
    checks++; if (cap_data.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      checks++; if (cap_data[0] !== 24'hABCDEF) begin errors++; $display("FAIL single_data got=%06h exp=abcdef", cap_data[0]); end
      checks++; if (cap_cyc[0] - k != 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", cap_cyc[0] - k); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty1 got=%b exp=1", bus.empty); end
    checks++; if (bus.level !== '0) begin errors++; $display("FAIL single_level0 got=%0d exp=0", bus.level); end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    hold = 1'b1; busy_len = 4; clear_caps();
    for (int i = 1; i <= 4; i++) drive_push(24'(i));
    idle(20);
    checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL b2b_no_strobe got=%0d exp=0", cap_data.size()); end
    checks++; if (bus.level !== 4'd4) begin errors++; $display("FAIL b2b_level got=%0d exp=4", bus.level); end
    hold = 1'b0;
    idle(60);
    checks++; if (cap_data.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", cap_data.size()); end
    for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
      checks++; if (cap_data[i] !== 24'(i + 1)) begin errors++; $display("FAIL b2b_data%0d got=%06h exp=%06h", i, cap_data[i], i + 1); end
      // Timeline: strobe, 1 cycle WAIT_TAKEN, busy until free rises, 1 IDLE, then the next strobe.
      if (i > 0) begin
        checks++; if (cap_cyc[i] - cap_cyc[i-1] != 6) begin errors++; $display("FAIL b2b_spacing%0d got=%0d exp=6", i, cap_cyc[i] - cap_cyc[i-1]); end
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    logic [23:0] w[3];
    hold = 1'b0; busy_len = 0; clear_caps();
    for (int i = 0; i < 3; i++) begin w[i] = 24'($urandom); drive_push(w[i]); end
    idle(70);
    checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL timeout_count got=%0d exp=3", cap_data.size()); end
    for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
      checks++; if (cap_data[i] !== w[i]) begin errors++; $display("FAIL timeout_data%0d got=%06h exp=%06h", i, cap_data[i], w[i]); end
      if (i > 0) begin
        checks++; if (cap_cyc[i] - cap_cyc[i-1] != TO + 2) begin errors++; $display("FAIL timeout_spacing%0d got=%0d exp=%0d", i, cap_cyc[i] - cap_cyc[i-1], TO + 2); end
      end
    end
    $display("test_timeout done");
  endtask

  // Random bursts pushed while the slave is held busy, then drained with a random busy length.
  task automatic test_overflow_random();
    logic [23:0] exp_q[$];
    logic [23:0] d;
    logic ovf;
    int k;
    for (int r = 0; r < 6; r++) begin
      hold = 1'b1; busy_len = $urandom_range(0, 5); clear_caps();
      exp_q.delete(); ovf = 1'b0;
      k = (r == 0) ? 9 : $urandom_range(1, 11);
      for (int j = 0; j < k; j++) begin
        d = 24'($urandom);
        if (exp_q.size() < DEPTH) exp_q.push_back(d); else ovf = 1'b1;
        drive_push(d);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      $display("burst round=%0d pushed=%0d stored=%0d busy_len=%0d", r, k, exp_q.size(), busy_len);
      checks++; if (bus.level !== 4'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_level got=%0d exp=%0d", r, bus.level, exp_q.size()); end
      checks++; if (bus.full !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL rnd%0d_full got=%b exp=%b", r, bus.full, exp_q.size() == DEPTH); end
      checks++; if (bus.overflow !== ovf) begin errors++; $display("FAIL rnd%0d_overflow got=%b exp=%b", r, bus.overflow, ovf); end
      hold = 1'b0;
      for (int t = 0; t < 400 && cap_data.size() < exp_q.size(); t++) @(negedge clk);
      idle(25);
      checks++; if (cap_data.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, cap_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_data.size(); i++) begin
        checks++; if (cap_data[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_data%0d got=%06h exp=%06h", r, i, cap_data[i], exp_q[i]); end
      end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rnd%0d_empty got=%b exp=1", r, bus.empty); end
      checks++; if (bus.overflow !== ovf) begin errors++; $display("FAIL rnd%0d_ovf_sticky got=%b exp=%b", r, bus.overflow, ovf); end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rnd%0d_ovf_flush got=%b exp=0", r, bus.overflow); end
    end
    $display("test_overflow_random done");
  endtask

  task automatic test_flush();
    logic [23:0] w[6];
    hold = 1'b0; busy_len = 12; clear_caps();
    for (int i = 0; i < 6; i++) begin w[i] = 24'($urandom); drive_push(w[i]); end
    checks++; if (bus.level !== 4'd5) begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", bus.level); end
    // A push in the same cycle as the flush must be discarded.
    bus.flush = 1'b1; bus.push_en = 1'b1; bus.push_data = 24'h5A5A5A;
    @(negedge clk);
    bus.flush = 1'b0; bus.push_en = 1'b0;
    checks++; if (bus.level !== '0) begin errors++; $display("FAIL flush_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%b exp=0", bus.overflow); end
    idle(60);
    checks++; if (cap_data.size() != 1) begin errors++; $display("FAIL flush_count got=%0d exp=1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      checks++; if (cap_data[0] !== w[0]) begin errors++; $display("FAIL flush_inflight got=%06h exp=%06h", cap_data[0], w[0]); end
    end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    logic seen;
    int k;
    hold = 1'b1; busy_len = 4; clear_caps();
    for (int i = 0; i < 4; i++) drive_push(24'h100 + 24'(i));
    hold = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.spi_wr_en === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_issue got=0 exp=1"); end
    reset = 1'b1;
    #1;
    checks++; if (bus.spi_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got=%b exp=0", bus.spi_wr_en); end
    checks++; if (bus.level !== '0) begin errors++; $display("FAIL rstmid_level got=%0d exp=0", bus.level); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b exp=1", bus.empty); end
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    clear_caps();
    k = cyc;
    drive_push(24'h123456);
    idle(20);
    checks++; if (cap_data.size() != 1) begin errors++; $display("FAIL rstmid_post_count got=%0d exp=1", cap_data.size()); end
    if (cap_data.size() >= 1) begin
      checks++; if (cap_data[0] !== 24'h123456) begin errors++; $display("FAIL rstmid_post_data got=%06h exp=123456", cap_data[0]); end
      checks++; if (cap_cyc[0] - k != 2) begin errors++; $display("FAIL rstmid_post_latency got=%0d exp=2", cap_cyc[0] - k); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    bus.push_en = 1'b0;
    bus.push_data = '0;
    bus.flush = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_overflow_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
